// File: rtl/cc_line_fill_unit.sv
// Cache-line fill unit: collects a wrapped, critical-word-first R burst into a full line
// and issues one SRAM write of {valid, tag} plus the line once the burst completes cleanly.
module cc_line_fill_unit #(
    parameter  int ADDR_W     = 32,
    parameter  int DATA_W     = 64,
    parameter  int LINE_BYTES = 64,
    parameter  int INDEX_W    = 9,
    localparam int BEATS      = LINE_BYTES * 8 / DATA_W,
    localparam int OFF_W      = $clog2(LINE_BYTES),
    localparam int BOFF_W     = $clog2(BEATS),
    localparam int TAG_W      = ADDR_W - INDEX_W - OFF_W,
    localparam int LINE_W     = LINE_BYTES * 8
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [DATA_W-1:0]   mem_rdata_i,
    input  logic [1:0]          mem_rresp_i,
    input  logic                mem_rlast_i,
    input  logic                mem_rvalid_i,
    input  logic                mem_rready_i,
    input  logic                miss_addr_fifo_empty_i,
    input  logic [ADDR_W-1:0]   miss_addr_fifo_rdata_i,
    output logic                miss_addr_fifo_rden_o,
    output logic                wren_o,
    output logic [INDEX_W-1:0]  waddr_o,
    output logic [TAG_W:0]      wdata_tag_o,
    output logic [LINE_W-1:0]   wdata_data_o,
    output logic                crit_valid_o,
    output logic [DATA_W-1:0]   crit_data_o,
    output logic                fill_err_o,
    output logic                orphan_err_o,
    output logic                busy_o
);

    typedef enum logic {IDLE, FILL} state_t;

    localparam logic [BOFF_W-1:0] LAST_CNT = BOFF_W'(BEATS - 1);

    // Handshake: a beat is consumed in any cycle where mem_rvalid_i and mem_rready_i
    // are both high; this block has no backpressure and never stalls the R channel.
    logic hs;
    assign hs = mem_rvalid_i & mem_rready_i;

    state_t                        state_q, state_d;
    logic [BOFF_W-1:0]             cnt_q, cnt_d;
    logic [BOFF_W-1:0]             boff_q, boff_d;
    logic [INDEX_W-1:0]            index_q, index_d;
    logic [TAG_W-1:0]              tag_q, tag_d;
    logic                          err_q, err_d;
    logic [BEATS-1:0][DATA_W-1:0]  line_q, line_d;

    logic                          wren_q, wren_d;
    logic [INDEX_W-1:0]            waddr_q, waddr_d;
    logic [TAG_W:0]                wtag_q, wtag_d;
    logic [LINE_W-1:0]             wdata_q, wdata_d;
    logic                          crit_valid_q, crit_valid_d;
    logic [DATA_W-1:0]             crit_data_q, crit_data_d;
    logic                          fill_err_q, fill_err_d;
    logic                          orphan_err_q, orphan_err_d;
    logic                          rden;

    logic [BOFF_W-1:0]             head_boff;
    logic [BOFF_W-1:0]             slot;
    logic                          err_acc;

    assign head_boff = miss_addr_fifo_rdata_i[OFF_W-1 -: BOFF_W];
    // Wrap of the critical-word-first order falls out of BOFF_W-bit truncation.
    assign slot      = boff_q + cnt_q;
    assign err_acc   = err_q | mem_rresp_i[1];

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        boff_d       = boff_q;
        index_d      = index_q;
        tag_d        = tag_q;
        err_d        = err_q;
        line_d       = line_q;
        wren_d       = 1'b0;
        waddr_d      = waddr_q;
        wtag_d       = wtag_q;
        wdata_d      = wdata_q;
        crit_valid_d = 1'b0;
        crit_data_d  = crit_data_q;
        fill_err_d   = 1'b0;
        orphan_err_d = 1'b0;
        rden         = 1'b0;

        case (state_q)
            IDLE: begin
                if (hs) begin
                    if (!miss_addr_fifo_empty_i) begin
                        rden              = 1'b1;
                        index_d           = miss_addr_fifo_rdata_i[OFF_W +: INDEX_W];
                        tag_d             = miss_addr_fifo_rdata_i[ADDR_W-1 -: TAG_W];
                        boff_d            = head_boff;
                        line_d[head_boff] = mem_rdata_i;
                        err_d             = mem_rresp_i[1];
                        crit_valid_d      = 1'b1;
                        crit_data_d       = mem_rdata_i;
                        if (mem_rlast_i) begin
                            fill_err_d = 1'b1;
                            cnt_d      = '0;
                        end else begin
                            cnt_d   = BOFF_W'(1);
                            state_d = FILL;
                        end
                    end else begin
                        orphan_err_d = 1'b1;
                    end
                end
            end
            FILL: begin
                if (hs) begin
                    line_d[slot] = mem_rdata_i;
                    if (cnt_q == LAST_CNT) begin
                        state_d = IDLE;
                        cnt_d   = '0;
                        err_d   = 1'b0;
                        if (mem_rlast_i && !err_acc) begin
                            wren_d  = 1'b1;
                            waddr_d = index_q;
                            wtag_d  = {1'b1, tag_q};
                            wdata_d = line_d;
                        end else begin
                            fill_err_d = 1'b1;
                        end
                    end else if (mem_rlast_i) begin
                        state_d    = IDLE;
                        cnt_d      = '0;
                        err_d      = 1'b0;
                        fill_err_d = 1'b1;
                    end else begin
                        cnt_d = cnt_q + BOFF_W'(1);
                        err_d = err_acc;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            boff_q       <= '0;
            index_q      <= '0;
            tag_q        <= '0;
            err_q        <= 1'b0;
            line_q       <= '0;
            wren_q       <= 1'b0;
            waddr_q      <= '0;
            wtag_q       <= '0;
            wdata_q      <= '0;
            crit_valid_q <= 1'b0;
            crit_data_q  <= '0;
            fill_err_q   <= 1'b0;
            orphan_err_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            boff_q       <= boff_d;
            index_q      <= index_d;
            tag_q        <= tag_d;
            err_q        <= err_d;
            line_q       <= line_d;
            wren_q       <= wren_d;
            waddr_q      <= waddr_d;
            wtag_q       <= wtag_d;
            wdata_q      <= wdata_d;
            crit_valid_q <= crit_valid_d;
            crit_data_q  <= crit_data_d;
            fill_err_q   <= fill_err_d;
            orphan_err_q <= orphan_err_d;
        end
    end

    assign miss_addr_fifo_rden_o = rden;
    assign wren_o                = wren_q;
    assign waddr_o               = waddr_q;
    assign wdata_tag_o           = wtag_q;
    assign wdata_data_o          = wdata_q;
    assign crit_valid_o          = crit_valid_q;
    assign crit_data_o           = crit_data_q;
    assign fill_err_o            = fill_err_q;
    assign orphan_err_o          = orphan_err_q;
    assign busy_o                = (state_q == FILL);

endmodule

// File: tb/tb_cc_line_fill_unit.sv
// Bench for cc_line_fill_unit: directed and randomized bursts against a transaction-level
// line model, plus a 2-beat parameter variant.
module tb_cc_line_fill_unit;

    localparam int ADDR_W     = 32;
    localparam int DATA_W     = 64;
    localparam int LINE_BYTES = 64;
    localparam int INDEX_W    = 9;
    localparam int BEATS      = 8;
    localparam int TAG_W      = 17;
    localparam int LINE_W     = 512;

    // clock / reset
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    // main DUT signals
    logic [DATA_W-1:0]  mem_rdata_i = '0;
    logic [1:0]         mem_rresp_i = '0;
    logic               mem_rlast_i = 1'b0;
    logic               mem_rvalid_i = 1'b0;
    logic               mem_rready_i = 1'b0;
    logic               fifo_empty = 1'b1;
    logic [ADDR_W-1:0]  fifo_rdata = '0;
    logic               rden_o, wren_o, crit_valid_o, fill_err_o, orphan_err_o, busy_o;
    logic [INDEX_W-1:0] waddr_o;
    logic [TAG_W:0]     wdata_tag_o;
    logic [LINE_W-1:0]  wdata_data_o;
    logic [DATA_W-1:0]  crit_data_o;

    cc_line_fill_unit #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .LINE_BYTES(LINE_BYTES), .INDEX_W(INDEX_W)) dut (
        .clk(clk), .rst_n(rst_n),
        .mem_rdata_i(mem_rdata_i), .mem_rresp_i(mem_rresp_i), .mem_rlast_i(mem_rlast_i),
        .mem_rvalid_i(mem_rvalid_i), .mem_rready_i(mem_rready_i),
        .miss_addr_fifo_empty_i(fifo_empty), .miss_addr_fifo_rdata_i(fifo_rdata),
        .miss_addr_fifo_rden_o(rden_o), .wren_o(wren_o), .waddr_o(waddr_o),
        .wdata_tag_o(wdata_tag_o), .wdata_data_o(wdata_data_o),
        .crit_valid_o(crit_valid_o), .crit_data_o(crit_data_o),
        .fill_err_o(fill_err_o), .orphan_err_o(orphan_err_o), .busy_o(busy_o)
    );

    // 2-beat variant: DATA_W=128, LINE_BYTES=32, INDEX_W=7 (TAG_W=20)
    logic [127:0] r2_data = '0;
    logic [1:0]   r2_resp = '0;
    logic         r2_last = 1'b0, r2_valid = 1'b0, r2_ready = 1'b1;
    logic         f2_empty = 1'b1;
    logic [31:0]  f2_rdata = '0;
    logic         rden2, wren2, crit_v2, ferr2, orph2, busy2;
    logic [6:0]   waddr2;
    logic [20:0]  wtag2;
    logic [255:0] wdata2;
    logic [127:0] crit_d2;

    cc_line_fill_unit #(.ADDR_W(32), .DATA_W(128), .LINE_BYTES(32), .INDEX_W(7)) dut2 (
        .clk(clk), .rst_n(rst_n),
        .mem_rdata_i(r2_data), .mem_rresp_i(r2_resp), .mem_rlast_i(r2_last),
        .mem_rvalid_i(r2_valid), .mem_rready_i(r2_ready),
        .miss_addr_fifo_empty_i(f2_empty), .miss_addr_fifo_rdata_i(f2_rdata),
        .miss_addr_fifo_rden_o(rden2), .wren_o(wren2), .waddr_o(waddr2),
        .wdata_tag_o(wtag2), .wdata_data_o(wdata2),
        .crit_valid_o(crit_v2), .crit_data_o(crit_d2),
        .fill_err_o(ferr2), .orphan_err_o(orph2), .busy_o(busy2)
    );

    // scoreboard and reference model state
    int n_checks = 0;
    int n_errors = 0;
    logic [ADDR_W-1:0] fifo_q[$];
    logic [LINE_W-1:0] exp_q[$];

    bit                m_in_burst;
    int                m_beat, m_boff;
    bit                m_err;
    logic [INDEX_W-1:0] m_index;
    logic [TAG_W-1:0]  m_tag;
    logic [DATA_W-1:0] m_line[BEATS];
    logic [DATA_W-1:0] beat_v[BEATS];

    logic               e_wren, e_crit_v, e_ferr, e_orph, e_busy;
    logic [INDEX_W-1:0] e_waddr;
    logic [TAG_W:0]     e_tag;
    logic [LINE_W-1:0]  e_data;
    logic [DATA_W-1:0]  e_crit_d;

    task automatic check(input string tag, input logic [1023:0] got, input logic [1023:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic model_clear();
        m_in_burst = 0; m_beat = 0; m_boff = 0; m_err = 0;
        e_wren = 0; e_crit_v = 0; e_ferr = 0; e_orph = 0; e_busy = 0;
        e_waddr = '0; e_tag = '0; e_data = '0; e_crit_d = '0;
        exp_q.delete();
    endtask

    task automatic check_all();
        check("wren", wren_o, e_wren);
        check("waddr", waddr_o, e_waddr);
        check("wtag", wdata_tag_o, e_tag);
        check("wdata", wdata_data_o, e_data);
        check("crit_valid", crit_valid_o, e_crit_v);
        check("crit_data", crit_data_o, e_crit_d);
        check("fill_err", fill_err_o, e_ferr);
        check("orphan_err", orphan_err_o, e_orph);
        check("busy", busy_o, e_busy);
        if (wren_o) begin
            if (exp_q.size() == 0) check("wren_unexpected", 1'b1, 1'b0);
            else check("line_sb", wdata_data_o, exp_q.pop_front());
        end
    endtask

    // One clock: drive at negedge, check the combinational pop, advance, check registers.
    task automatic step(input logic v, input logic r, input logic [DATA_W-1:0] d,
                        input logic [1:0] resp, input logic last);
        logic exp_rden;
        logic [ADDR_W-1:0] a;
        mem_rvalid_i = v; mem_rready_i = r; mem_rdata_i = d;
        mem_rresp_i = resp; mem_rlast_i = last;
        fifo_empty = (fifo_q.size() == 0);
        fifo_rdata = fifo_empty ? '0 : fifo_q[0];
        exp_rden = 1'b0;
        e_wren = 0; e_crit_v = 0; e_ferr = 0; e_orph = 0;
        if (v && r) begin
            if (!m_in_burst) begin
                if (fifo_q.size() == 0) begin
                    e_orph = 1;
                end else begin
                    exp_rden = 1'b1;
                    a = fifo_q.pop_front();
                    m_boff  = int'((a % LINE_BYTES) / (DATA_W / 8));
                    m_index = INDEX_W'((a / LINE_BYTES) % (1 << INDEX_W));
                    m_tag   = TAG_W'(a / (LINE_BYTES << INDEX_W));
                    m_line[m_boff] = d;
                    m_beat = 1; m_err = resp[1];
                    e_crit_v = 1; e_crit_d = d;
                    if (last) e_ferr = 1;
                    else m_in_burst = 1;
                end
            end else begin
                m_line[(m_boff + m_beat) % BEATS] = d;
                m_err = m_err | resp[1];
                m_beat++;
                if (m_beat == BEATS) begin
                    m_in_burst = 0;
                    if (last && !m_err) begin
                        e_wren = 1; e_waddr = m_index; e_tag = {1'b1, m_tag};
                        for (int k = 0; k < BEATS; k++) e_data[k*DATA_W +: DATA_W] = m_line[k];
                        exp_q.push_back(e_data);
                    end else begin
                        e_ferr = 1;
                    end
                end else if (last) begin
                    m_in_burst = 0;
                    e_ferr = 1;
                end
            end
        end
        e_busy = m_in_burst;
        #1 check("rden", rden_o, exp_rden);
        @(posedge clk);
        @(negedge clk);
        check_all();
    endtask

    task automatic idle_step();
        if ($urandom_range(0, 1) == 0) step(1'b0, 1'b1, '0, 2'b00, 1'b0);
        else step(1'b1, 1'b0, {$urandom, $urandom}, 2'b00, 1'b1);
    endtask

    // rlast_at: beat index carrying rlast (BEATS = never); err_at: beat with SLVERR (-1 = none)
    task automatic burst(input int rlast_at, input int err_at, input int max_gap, input bit rnd);
        logic [1:0] resp;
        for (int i = 0; i < BEATS; i++) begin
            beat_v[i] = rnd ? {$urandom, $urandom} : (64'hD000_0000_0000_0000 + 64'(i));
            repeat ($urandom_range(0, max_gap)) idle_step();
            resp = (i == err_at) ? {1'b1, 1'($urandom_range(0, 1))} : {1'b0, 1'($urandom_range(0, 1))};
            step(1'b1, 1'b1, beat_v[i], resp, i == rlast_at);
            if (i == rlast_at) break;
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        mem_rvalid_i = 1'b0; mem_rready_i = 1'b0; mem_rlast_i = 1'b0;
        model_clear();
        #1 check_all();
        check("rden_rst", rden_o, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        model_clear();
        repeat (3) @(negedge clk);
        do_reset();

        // aligned fill
        fifo_q.push_back(32'h0001_2340);
        burst(BEATS - 1, -1, 0, 0);
        check("aligned_waddr", waddr_o, 9'h08D);
        check("aligned_tag", wdata_tag_o, {1'b1, 17'h00002});
        for (int k = 0; k < BEATS; k++) check("aligned_slot", wdata_data_o[k*DATA_W +: DATA_W], beat_v[k]);

        // wrapped fill starting at beat offset 5
        fifo_q.push_back(32'h0001_2368);
        burst(BEATS - 1, -1, 0, 1);
        check("wrap_slot5", wdata_data_o[5*DATA_W +: DATA_W], beat_v[0]);
        check("wrap_slot0", wdata_data_o[0 +: DATA_W], beat_v[3]);
        check("wrap_slot4", wdata_data_o[4*DATA_W +: DATA_W], beat_v[7]);
        check("wrap_crit", crit_data_o, beat_v[0]);

        // SLVERR on beat 3, then a clean burst, then early rlast on beat 5
        fifo_q.push_back(32'h0000_1000);
        fifo_q.push_back(32'h0000_2040);
        burst(BEATS - 1, 2, 0, 1);
        check("err_fill_err", fill_err_o, 1'b1);
        check("err_no_wren", wren_o, 1'b0);
        burst(BEATS - 1, -1, 0, 1);
        check("after_err_wren", wren_o, 1'b1);
        fifo_q.push_back(32'h0000_3080);
        burst(4, -1, 1, 1);
        check("early_fill_err", fill_err_o, 1'b1);
        check("early_idle", busy_o, 1'b0);
        // final beat without rlast
        fifo_q.push_back(32'h0000_30C0);
        burst(BEATS, -1, 0, 1);
        check("nolast_fill_err", fill_err_o, 1'b1);

        // back-to-back, no gap
        fifo_q.push_back(32'h0001_0000);
        fifo_q.push_back(32'h0002_0FC0);
        burst(BEATS - 1, -1, 0, 1);
        check("b2b_wren0", wren_o, 1'b1);
        burst(BEATS - 1, -1, 0, 1);
        check("b2b_wren1", wren_o, 1'b1);
        check("b2b_waddr1", waddr_o, 9'h03F);

        // orphan beat
        step(1'b1, 1'b1, 64'h0BAD, 2'b00, 1'b0);
        check("orphan", orphan_err_o, 1'b1);

        // reset after beat 4, then a fresh fill
        fifo_q.push_back(32'h0000_5000);
        for (int i = 0; i < 4; i++) step(1'b1, 1'b1, {$urandom, $urandom}, 2'b00, 1'b0);
        do_reset();
        fifo_q.push_back(32'h0000_6128);
        burst(BEATS - 1, -1, 0, 1);
        check("post_reset_wren", wren_o, 1'b1);

        // randomized traffic
        for (int n = 0; n < 250; n++) begin
            int kind;
            repeat ($urandom_range(0, 2)) if (fifo_q.size() < 3) fifo_q.push_back($urandom);
            kind = $urandom_range(0, 9);
            case (kind)
                0: burst(BEATS - 1, $urandom_range(0, BEATS - 1), 2, 1);
                1: burst($urandom_range(0, BEATS - 2), -1, 2, 1);
                2: burst(BEATS, -1, 1, 1);
                default: burst(BEATS - 1, -1, (kind > 6) ? 3 : 0, 1);
            endcase
        end
        repeat (2) step(1'b0, 1'b0, '0, 2'b00, 1'b0);
        check("sb_drain", 32'(exp_q.size()), 32'd0);

        // 2-beat variant, address 0x1230: boff 1, index 0x11, tag 1
        mem_rvalid_i = 1'b0;
        f2_empty = 1'b0; f2_rdata = 32'h0000_1230;
        r2_valid = 1'b1; r2_data = 128'hA0A0_0000_1111; r2_last = 1'b0;
        #1 check("v2_rden", rden2, 1'b1);
        @(posedge clk); @(negedge clk);
        check("v2_crit_valid", crit_v2, 1'b1);
        check("v2_crit_data", crit_d2, 128'hA0A0_0000_1111);
        check("v2_busy", busy2, 1'b1);
        f2_empty = 1'b1; r2_data = 128'hA1A1_0000_2222; r2_last = 1'b1;
        #1 check("v2_no_rden", rden2, 1'b0);
        @(posedge clk); @(negedge clk);
        r2_valid = 1'b0; r2_last = 1'b0;
        check("v2_wren", wren2, 1'b1);
        check("v2_waddr", waddr2, 7'h11);
        check("v2_tag", wtag2, {1'b1, 20'h00001});
        check("v2_data", wdata2, {128'hA0A0_0000_1111, 128'hA1A1_0000_2222});
        check("v2_idle", busy2, 1'b0);
        @(posedge clk); @(negedge clk);
        check("v2_wren_pulse", wren2, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
